// File: rtl/fir_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fir_capture_buffer
// Purpose  : Triggered capture of the filter output stream into a 32-entry
//            circular RAM. Freezes on a rising crossing of trig_level with
//            PRETRIG samples kept ahead of the trigger; the frozen window is
//            read back through a registered port, index 0 = oldest sample.
// Options  : CAPTURE_PEAK_EN - when defined, peak_max/peak_min track the
//            signed extremes of all samples accepted since arm; otherwise
//            both outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module fir_capture_buffer #(
  parameter int N       = 16,
  parameter int PRETRIG = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] sample_in,
  input  logic         sample_valid,
  input  logic         arm,
  input  logic [N-1:0] trig_level,
  input  logic         rd_en,
  input  logic [4:0]   rd_addr,
  output logic [N-1:0] rd_data,
  output logic         rd_valid,
  output logic         busy,
  output logic         done,
  output logic [4:0]   trig_index,
  output logic [N-1:0] peak_max,
  output logic [N-1:0] peak_min
);

  localparam logic [4:0] c_PRETRIG = PRETRIG[4:0];
  localparam logic [4:0] c_POSTCNT = 5'd31 - c_PRETRIG;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_TRIG = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t       state_q;
  logic [N-1:0] mem_q [32];
  logic [4:0]   wr_ptr_q;
  logic [4:0]   wr_ptr_d;
  logic [4:0]   pre_cnt_q;
  logic [4:0]   post_cnt_q;
  logic [N-1:0] prev_q;
  logic         prev_valid_q;
  logic [4:0]   trig_index_q;
  logic [N-1:0] rd_data_q;
  logic         rd_valid_q;
  logic         busy_q;
  logic         done_q;

  logic         w_start;
  logic         w_accept;
  logic         w_cross;
  logic [4:0]   w_rd_phys;

  // A new capture may only be started from IDLE or DONE.
  assign w_start  = arm && (state_q == S_IDLE || state_q == S_DONE);
  assign w_accept = sample_valid &&
                    (state_q == S_PRE || state_q == S_TRIG || state_q == S_POST);
  assign w_cross  = prev_valid_q &&
                    ($signed(prev_q) <  $signed(trig_level)) &&
                    ($signed(sample_in) >= $signed(trig_level));
  assign wr_ptr_d  = wr_ptr_q + 5'd1;
  // Logical index 0 sits PRETRIG entries before the trigger sample.
  assign w_rd_phys = trig_index_q - c_PRETRIG + rd_addr;

  // Capture RAM write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      mem_q[wr_ptr_q] <= sample_in;
    end
  end

  // Capture FSM, write pointer, trigger latch and registered read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= 5'd0;
      pre_cnt_q    <= 5'd0;
      post_cnt_q   <= 5'd0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      trig_index_q <= 5'd0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // Reads are served only from a frozen window; otherwise data holds.
      rd_valid_q <= 1'b0;
      if (state_q == S_DONE && rd_en) begin
        rd_data_q  <= mem_q[w_rd_phys];
        rd_valid_q <= 1'b1;
      end

      if (w_accept) begin
        wr_ptr_q     <= wr_ptr_d;
        prev_q       <= sample_in;
        prev_valid_q <= 1'b1;
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            wr_ptr_q     <= 5'd0;
            pre_cnt_q    <= 5'd0;
            prev_valid_q <= 1'b0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            state_q      <= (c_PRETRIG == 5'd0) ? S_TRIG : S_PRE;
          end
        end
        S_PRE: begin
          if (w_accept) begin
            if ((pre_cnt_q + 5'd1) == c_PRETRIG) begin
              state_q <= S_TRIG;
            end
            pre_cnt_q <= pre_cnt_q + 5'd1;
          end
        end
        S_TRIG: begin
          if (w_accept && w_cross) begin
            trig_index_q <= wr_ptr_q;
            post_cnt_q   <= c_POSTCNT;
            if (c_POSTCNT == 5'd0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_POST;
            end
          end
        end
        S_POST: begin
          if (w_accept) begin
            post_cnt_q <= post_cnt_q - 5'd1;
            if (post_cnt_q == 5'd1) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign trig_index = trig_index_q;

`ifdef CAPTURE_PEAK_EN
  logic [N-1:0] peak_max_q;
  logic [N-1:0] peak_min_q;
  logic         peak_first_q;

  // Signed extremes of accepted samples; the first sample after arm seeds both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_max_q   <= '0;
      peak_min_q   <= '0;
      peak_first_q <= 1'b0;
    end else if (w_start) begin
      peak_first_q <= 1'b1;
    end else if (w_accept) begin
      peak_first_q <= 1'b0;
      if (peak_first_q || ($signed(sample_in) > $signed(peak_max_q))) begin
        peak_max_q <= sample_in;
      end
      if (peak_first_q || ($signed(sample_in) < $signed(peak_min_q))) begin
        peak_min_q <= sample_in;
      end
    end
  end

  assign peak_max = peak_max_q;
  assign peak_min = peak_min_q;
`else
  assign peak_max = '0;
  assign peak_min = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_capture_buffer
// Purpose  : Self-checking bench for fir_capture_buffer. A sample-history
//            model (global sample numbering, window located by arithmetic on
//            the trigger number) is compared every cycle; directed scenarios
//            add hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_capture_buffer;

  localparam int N       = 16;
  localparam int PRETRIG = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] sample_in = '0;
  logic         sample_valid = 1'b0;
  logic         arm = 1'b0;
  logic [N-1:0] trig_level = '0;
  logic         rd_en = 1'b0;
  logic [4:0]   rd_addr = '0;
  logic [N-1:0] rd_data;
  logic         rd_valid;
  logic         busy;
  logic         done;
  logic [4:0]   trig_index;
  logic [N-1:0] peak_max;
  logic [N-1:0] peak_min;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  fir_capture_buffer #(.N(N), .PRETRIG(PRETRIG)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .arm(arm), .trig_level(trig_level), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .trig_index(trig_index), .peak_max(peak_max), .peak_min(peak_min)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [N-1:0] m_hist [1024];
  int           m_n;
  int           m_trig;
  bit           m_busy, m_done, m_rd_valid, m_first;
  logic [N-1:0] m_prev, m_rd_data, m_pmax, m_pmin;
  logic [4:0]   m_trig_index;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_done = 0; m_rd_valid = 0; m_rd_data = '0;
      m_trig_index = '0; m_pmax = '0; m_pmin = '0; m_first = 0;
      m_n = 0; m_trig = -1;
    end else begin
      if (m_done && rd_en) begin
        m_rd_data  = m_hist[(m_trig - PRETRIG + int'(rd_addr)) % 1024];
        m_rd_valid = 1;
      end else begin
        m_rd_valid = 0;
      end
      if (!m_busy && arm) begin
        m_busy = 1; m_done = 0; m_n = 0; m_trig = -1; m_first = 1;
      end else if (m_busy && sample_valid) begin
        if (m_trig < 0 && m_n >= PRETRIG && m_n >= 1 &&
            $signed(m_prev) < $signed(trig_level) &&
            $signed(sample_in) >= $signed(trig_level)) begin
          m_trig       = m_n;
          m_trig_index = 5'(m_n % 32);
        end
        m_hist[m_n % 1024] = sample_in;
        m_prev = sample_in;
`ifdef CAPTURE_PEAK_EN
        if (m_first || $signed(sample_in) > $signed(m_pmax)) m_pmax = sample_in;
        if (m_first || $signed(sample_in) < $signed(m_pmin)) m_pmin = sample_in;
`endif
        m_first = 0;
        m_n++;
        if (m_trig >= 0 && m_n == m_trig + 32 - PRETRIG) begin
          m_busy = 0; m_done = 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset && run_cmp) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
      chk("rd_data", 32'(rd_data), 32'(m_rd_data));
      chk("trig_index", 32'(trig_index), 32'(m_trig_index));
      chk("peak_max", 32'(peak_max), 32'(m_pmax));
      chk("peak_min", 32'(peak_min), 32'(m_pmin));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit v, input logic [15:0] s, input bit a,
                     input bit re, input logic [4:0] ad);
    sample_valid = v; sample_in = s; arm = a; rd_en = re; rd_addr = ad;
    @(posedge clk); #1;
    sample_valid = 0; arm = 0; rd_en = 0;
  endtask

  task automatic run_ramp(input bit toggle);
    cyc(0, 16'h0, 1, 0, 0);
    chk("arm_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 44; k++) begin
      if (k == 43) chk("done_before_last", 32'(done), 32'd0);
      cyc(1, 16'(k - 20), 0, 0, 0);
      if (toggle) begin
        if (k == 43) chk("done_after_last", 32'(done), 32'd1);
        cyc(0, 16'h7FFF, 0, 0, 0);
      end
    end
    chk("done_after_last", 32'(done), 32'd1);
    chk("ramp_trig_index", 32'(trig_index), 32'd20);
  endtask

  task automatic rd_lit(input logic [4:0] ad, input logic [15:0] exp);
    cyc(0, 16'h0, 0, 1, ad);
    chk("rd_valid_pulse", 32'(rd_valid), 32'd1);
    chk("rd_lit", 32'(rd_data), 32'(exp));
  endtask

  task automatic ramp_reads();
    rd_lit(5'd0, 16'hFFF8);
    rd_lit(5'd8, 16'h0000);
    rd_lit(5'd31, 16'h0017);
    for (int a = 0; a < 32; a++) cyc(0, 16'h0, 0, 1, 5'(a));
    cyc(0, 16'h0, 0, 0, 0);
    chk("rd_valid_drop", 32'(rd_valid), 32'd0);
  endtask

  initial begin
    // reset values
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_trig_index", 32'(trig_index), 32'd0);
    chk("rst_peak_max", 32'(peak_max), 32'd0);
    chk("rst_peak_min", 32'(peak_min), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    run_cmp = 1'b1;
    cyc(0, 16'h0, 0, 1, 5'd3);
    chk("rd_idle_ignored", 32'(rd_valid), 32'd0);

    // ramp capture, valid every cycle
    run_ramp(0);
`ifdef CAPTURE_PEAK_EN
    chk("ramp_peak_max", 32'(peak_max), 32'h0017);
    chk("ramp_peak_min", 32'(peak_min), 32'hFFEC);
`else
    chk("ramp_peak_max", 32'(peak_max), 32'h0);
    chk("ramp_peak_min", 32'(peak_min), 32'h0);
`endif
    ramp_reads();

    // reset while in POST
    cyc(0, 16'h0, 1, 0, 0);
    for (int k = 0; k < 26; k++) cyc(1, 16'(k - 20), 0, 0, 0);
    chk("post_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
    chk("mid_rst_trig_index", 32'(trig_index), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // ramp with valid every other cycle
    run_ramp(1);
    ramp_reads();

    // signed compare: 0xFFFF then 0x0001 triggers
    cyc(0, 16'h0, 1, 0, 0);
    for (int k = 0; k < 9; k++) cyc(1, 16'hFFFF, 0, 0, 0);
    cyc(1, 16'h0001, 0, 0, 0);
    chk("signed_trig_index", 32'(trig_index), 32'd9);
    for (int k = 0; k < 23; k++) cyc(1, 16'h0001, 0, 0, 0);
    chk("signed_done", 32'(done), 32'd1);
    rd_lit(5'd8, 16'h0001);
    rd_lit(5'd7, 16'hFFFF);

    // signed compare: 0x0001 then 0xFFFF must not trigger
    cyc(0, 16'h0, 1, 0, 0);
    for (int k = 0; k < 9; k++) cyc(1, 16'h0001, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(1, 16'hFFFF, 0, 0, 0);
    chk("neg_busy", 32'(busy), 32'd1);
    chk("neg_done", 32'(done), 32'd0);
    chk("neg_trig_index", 32'(trig_index), 32'd9);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // no crossing for 100 samples; arm pulses ignored
    cyc(0, 16'h0, 1, 0, 0);
    for (int i = 0; i < 100; i++) begin
      cyc(1, 16'h0005, (i % 10) == 3, 0, 0);
      chk("nocross_busy", 32'(busy), 32'd1);
      chk("nocross_done", 32'(done), 32'd0);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // arm together with a read in DONE
    run_ramp(0);
    cyc(0, 16'h0, 1, 1, 5'd3);
    chk("armrd_valid", 32'(rd_valid), 32'd1);
    chk("armrd_data", 32'(rd_data), 32'hFFFB);
    chk("armrd_done", 32'(done), 32'd0);
    chk("armrd_busy", 32'(busy), 32'd1);
    cyc(0, 16'h0, 0, 0, 0);
    chk("armrd_valid_drop", 32'(rd_valid), 32'd0);
    cyc(0, 16'h0, 0, 0, 0);

    run_cmp = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
